word_scramble_ctrl: RTL and testbench
=====================================

// Module: word_scramble_ctrl
// PURPOSE
//  Owns the active puzzle word. Sequences the letter-swap datapath for the game FSM:
//  - loads target word; scrambles it with LFSR-driven swaps on scramble request
//  - applies player flips; reports when the working word matches the target again
//  Sits between the game FSM (scram_pls/flip_pls/indices/is_correct) and the display path (word_out).
// PARAMETERS
//  MAX_LETT     6       letter slots held; lett_num must be 4..MAX_LETT
//  LETT_W       5       bits per letter code (0=blank, 1..26=A..Z)
//  SCRAM_SWAPS  8       random swaps per scramble pass
//  LFSR_SEED    8'hA5   LFSR reset value, nonzero
// PORTS
//  clk         in   1               system clock, rising edge
//  rst         in   1               asynchronous reset, active-low
//  load_pls    in   1               capture word_in as target and working word
//  word_in     in   MAX_LETT*LETT_W target word, slot 0 in LSBs
//  lett_num    in   3               active letter count, sampled with load_pls
//  scram_pls   in   1               start a scramble pass
//  flip_pls    in   1               swap slots ind1/ind2 of the working word
//  ind1, ind2  in   3               flip slot indices
//  busy        out  1               high in any state except IDLE
//  is_correct  out  1               1-cycle pulse: working word == target after a flip
//  flip_err    out  1               1-cycle pulse: flip rejected (index >= active count)
//  word_out    out  MAX_LETT*LETT_W working word, registered
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; busy/is_correct/flip_err=0; word_out/target=0; count=MAX_LETT; LFSR=LFSR_SEED.
//  - States: IDLE, SCRAMBLE, FIXUP, CHECK.
//  - load_pls has highest priority in every state: aborts any operation; state->IDLE.
//    - Captures word_in into target and working word.
//    - Slots >= lett_num are forced to 0.
//    - Active count = lett_num, clamped to 4..MAX_LETT.
//  - Simultaneous requests in IDLE: priority order is load_pls, then scram_pls, then flip_pls.
//  - Requests arriving while busy (except load_pls) are dropped, with no error pulse.
//  - SCRAMBLE:
//    - One swap per cycle for SCRAM_SWAPS cycles. LFSR advances every SCRAMBLE cycle.
//    - a = lfsr[2:0] and b = lfsr[5:3], each reduced by subtracting the active count if >= the count.
//    - If a==b then b=(a+1) mod count.
//  - FIXUP (1 cycle):
//    - If working word == target and slot0 != slot1, swap slots 0 and 1.
//    - Then -> IDLE. Total busy for a scramble = SCRAM_SWAPS+1 cycles.
//  - Flip accepted in IDLE, edge k:
//    - If ind1 or ind2 >= count: flip_err pulses at k+1; no change; stay IDLE.
//    - Otherwise the swap is registered at edge k and state=CHECK.
//    - ind1==ind2 is legal and leaves the word unchanged.
//  - CHECK (1 cycle): is_correct <= (working==target), comparing active slots only; -> IDLE.
//    - is_correct is therefore visible in the cycle after CHECK.
//  - Flip latency: request edge k -> word_out updated after k -> is_correct high for one cycle after edge k+1.
//  - is_correct never fires from load or scramble; only from a flip.
// CONFIGURATION
//  SCRAM_SWAP_COUNT_EN defined:
//    - Adds output swap_cnt [7:0]: accepted (non-error) flips since the last scramble or load.
//    - Saturates at 8'hFF; cleared at scramble start and on load_pls; reset value 0.
//  SCRAM_SWAP_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Package word_scramble_pkg holds:
//    - state enum; LETT_W and MAX_LETT defaults
//    - LFSR polynomial constant (x^8+x^6+x^5+x^4+1)
//    - letter code constants (BLANK=0, A=1)
//  - Sub-module scram_lfsr: 8-bit Galois LFSR with advance enable, async active-low reset to seed.
//  - Swap logic and compare stay inline.
// TESTING
//  1 Reset mid-scramble: rst low for 2 cycles -> busy=0, word_out=0, LFSR back to LFSR_SEED;
//    the next scramble reproduces the post-reset sequence.
//  2 Load "ABCD" (1,2,3,4), lett_num=4, then scram_pls -> busy exactly 9 cycles;
//    result is a permutation of {1,2,3,4}, differs from target, slots 4-5=0.
//  3 Load "ABCD", flip 0<->1 then flip 0<->1 -> is_correct=0 after first CHECK,
//    is_correct=1 for exactly one cycle after second.
//  4 lett_num=4, flip ind1=4 ind2=0 -> flip_err one cycle, word_out unchanged, busy stays 0.
//  5 scram_pls and flip_pls same cycle -> scramble runs, flip dropped;
//    flip during busy -> no word change.
//  6 load_pls during SCRAMBLE cycle 3 -> next cycle IDLE, word_out=new word;
//    with SCRAM_SWAP_COUNT_EN, 300 flips -> swap_cnt=255.

Source files
------------

// File: rtl/word_scramble_pkg.sv
// Shared types and constants for the word scramble controller.
// Holds the FSM state encoding, default geometry, the LFSR polynomial,
// letter code constants and the LFSR step helper.
package word_scramble_pkg;

  localparam int unsigned MAX_LETT_DEF = 6;
  localparam int unsigned LETT_W_DEF   = 5;

  // x^8 + x^6 + x^5 + x^4 + 1 in right-shifting Galois form
  localparam logic [7:0] LFSR_POLY = 8'hB8;

  localparam logic [4:0] LETT_BLANK = 5'd0;
  localparam logic [4:0] LETT_A     = 5'd1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCRAMBLE = 2'd1,
    ST_FIXUP    = 2'd2,
    ST_CHECK    = 2'd3
  } state_e;

  // One Galois step: shift right, fold the polynomial in when a one falls out.
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    logic [7:0] nxt;
    if (cur[0]) begin
      nxt = (cur >> 1) ^ LFSR_POLY;
    end else begin
      nxt = cur >> 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/scram_lfsr.sv
// 8-bit Galois LFSR that supplies swap indices during a scramble pass.
// Advances only while adv_i is high; reset restores the seed.
module scram_lfsr
  import word_scramble_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;

  // LFSR state register: hold unless asked to advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else if (adv_i) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end else begin
      lfsr_q <= lfsr_q;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/word_scramble_ctrl.sv
// Puzzle word owner: loads the target, scrambles it with LFSR-driven swaps,
// applies player flips and flags when the working word matches the target.
// Optional feature macro: SCRAM_SWAP_COUNT_EN adds the swap_cnt output
// (accepted flips since the last scramble or load, saturating at 255).
module word_scramble_ctrl
  import word_scramble_pkg::*;
#(
  parameter int unsigned MAX_LETT    = MAX_LETT_DEF,
  parameter int unsigned LETT_W      = LETT_W_DEF,
  parameter int unsigned SCRAM_SWAPS = 8,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_pls,
  input  logic [MAX_LETT*LETT_W-1:0] word_in,
  input  logic [2:0]                 lett_num,
  input  logic                       scram_pls,
  input  logic                       flip_pls,
  input  logic [2:0]                 ind1,
  input  logic [2:0]                 ind2,
  output logic                       busy,
  output logic                       is_correct,
  output logic                       flip_err,
  output logic [MAX_LETT*LETT_W-1:0] word_out
`ifdef SCRAM_SWAP_COUNT_EN
  ,
  output logic [7:0]                 swap_cnt
`endif
);

  localparam int unsigned WORD_W  = MAX_LETT * LETT_W;
  localparam int unsigned SWP_W   = $clog2(SCRAM_SWAPS + 1);
  localparam logic [2:0]  CNT_MAX = 3'(MAX_LETT);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [WORD_W-1:0]  target_q, target_d;
  logic [2:0]         count_q, count_d;
  logic [SWP_W-1:0]   swaps_q, swaps_d;
  logic               busy_q, busy_d;
  logic               is_correct_q, is_correct_d;
  logic               flip_err_q, flip_err_d;
`ifdef SCRAM_SWAP_COUNT_EN
  logic [7:0]         swap_cnt_q, swap_cnt_d;
`endif

  logic [7:0]         lfsr_s;
  logic               lfsr_adv_s;
  logic [2:0]         raw_a_s, raw_b_s, a_s, b_red_s, b_s;
  logic [2:0]         count_ld_s;
  logic [WORD_W-1:0]  load_word_s;
  logic [WORD_W-1:0]  active_mask_s;

  // Exchange two letter slots; slot selection uses constant part-selects only.
  function automatic logic [WORD_W-1:0] swap_slots(input logic [WORD_W-1:0] w,
                                                   input logic [2:0] x,
                                                   input logic [2:0] y);
    logic [WORD_W-1:0] r;
    logic [LETT_W-1:0] lx, ly;
    lx = '0;
    ly = '0;
    for (int i = 0; i < int'(MAX_LETT); i++) begin
      if (3'(i) == x) lx = w[i*LETT_W +: LETT_W];
      else            lx = lx;
      if (3'(i) == y) ly = w[i*LETT_W +: LETT_W];
      else            ly = ly;
    end
    r = w;
    for (int i = 0; i < int'(MAX_LETT); i++) begin
      if (3'(i) == x)      r[i*LETT_W +: LETT_W] = ly;
      else if (3'(i) == y) r[i*LETT_W +: LETT_W] = lx;
      else                 r[i*LETT_W +: LETT_W] = w[i*LETT_W +: LETT_W];
    end
    return r;
  endfunction

  scram_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .adv_i  (lfsr_adv_s),
    .lfsr_o (lfsr_s)
  );

  // Reduce the LFSR fields into two distinct in-range slot indices
  always_comb begin
    raw_a_s = lfsr_s[2:0];
    raw_b_s = lfsr_s[5:3];
    if (raw_a_s >= count_q) a_s = raw_a_s - count_q;
    else                    a_s = raw_a_s;
    if (raw_b_s >= count_q) b_red_s = raw_b_s - count_q;
    else                    b_red_s = raw_b_s;
    if (b_red_s == a_s) begin
      if (a_s + 3'd1 >= count_q) b_s = 3'd0;
      else                       b_s = a_s + 3'd1;
    end else begin
      b_s = b_red_s;
    end
  end

  // Load-time word with unused slots blanked, active-slot mask, clamped count
  always_comb begin
    load_word_s   = '0;
    active_mask_s = '0;
    for (int i = 0; i < int'(MAX_LETT); i++) begin
      if (i < int'(lett_num)) load_word_s[i*LETT_W +: LETT_W] = word_in[i*LETT_W +: LETT_W];
      else                    load_word_s[i*LETT_W +: LETT_W] = '0;
      if (i < int'(count_q))  active_mask_s[i*LETT_W +: LETT_W] = '1;
      else                    active_mask_s[i*LETT_W +: LETT_W] = '0;
    end
    if (lett_num < 3'd4)          count_ld_s = 3'd4;
    else if (lett_num > CNT_MAX)  count_ld_s = CNT_MAX;
    else                          count_ld_s = lett_num;
  end

  // Next-state logic: load overrides everything, then per-state sequencing
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    target_d     = target_q;
    count_d      = count_q;
    swaps_d      = swaps_q;
    is_correct_d = 1'b0;
    flip_err_d   = 1'b0;
    lfsr_adv_s   = 1'b0;
`ifdef SCRAM_SWAP_COUNT_EN
    swap_cnt_d   = swap_cnt_q;
`endif
    if (load_pls) begin
      state_d  = ST_IDLE;
      word_d   = load_word_s;
      target_d = load_word_s;
      count_d  = count_ld_s;
      swaps_d  = '0;
`ifdef SCRAM_SWAP_COUNT_EN
      swap_cnt_d = 8'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (scram_pls) begin
            state_d = ST_SCRAMBLE;
            swaps_d = '0;
`ifdef SCRAM_SWAP_COUNT_EN
            swap_cnt_d = 8'd0;
`endif
          end else if (flip_pls) begin
            if ((ind1 >= count_q) || (ind2 >= count_q)) begin
              flip_err_d = 1'b1;
            end else begin
              word_d  = swap_slots(word_q, ind1, ind2);
              state_d = ST_CHECK;
`ifdef SCRAM_SWAP_COUNT_EN
              if (swap_cnt_q == 8'hFF) swap_cnt_d = 8'hFF;
              else                     swap_cnt_d = swap_cnt_q + 8'd1;
`endif
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SCRAMBLE: begin
          lfsr_adv_s = 1'b1;
          word_d     = swap_slots(word_q, a_s, b_s);
          swaps_d    = swaps_q + SWP_W'(1);
          if (swaps_q == SWP_W'(SCRAM_SWAPS - 1)) state_d = ST_FIXUP;
          else                                     state_d = ST_SCRAMBLE;
        end
        ST_FIXUP: begin
          // Never hand the player an already-solved word if a swap can fix it
          if ((word_q == target_q) &&
              (word_q[LETT_W-1:0] != word_q[2*LETT_W-1:LETT_W])) begin
            word_d = swap_slots(word_q, 3'd0, 3'd1);
          end else begin
            word_d = word_q;
          end
          state_d = ST_IDLE;
        end
        ST_CHECK: begin
          is_correct_d = (((word_q ^ target_q) & active_mask_s) == '0);
          state_d      = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      target_q     <= '0;
      count_q      <= CNT_MAX;
      swaps_q      <= '0;
      busy_q       <= 1'b0;
      is_correct_q <= 1'b0;
      flip_err_q   <= 1'b0;
`ifdef SCRAM_SWAP_COUNT_EN
      swap_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      target_q     <= target_d;
      count_q      <= count_d;
      swaps_q      <= swaps_d;
      busy_q       <= busy_d;
      is_correct_q <= is_correct_d;
      flip_err_q   <= flip_err_d;
`ifdef SCRAM_SWAP_COUNT_EN
      swap_cnt_q   <= swap_cnt_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign is_correct = is_correct_q;
  assign flip_err   = flip_err_q;
  assign word_out   = word_q;
`ifdef SCRAM_SWAP_COUNT_EN
  assign swap_cnt   = swap_cnt_q;
`endif

endmodule

// File: tb/tb_word_scramble_ctrl.sv
// Self-checking bench for word_scramble_ctrl: a table of load/flip vectors,
// hand-written multi-cycle sequences and a randomized run against a
// letter-array model of the puzzle rules.
module tb_word_scramble_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_pls, scram_pls, flip_pls;
  logic [29:0] word_in;
  logic [2:0]  lett_num, ind1, ind2;
  logic        busy, is_correct, flip_err;
  logic [29:0] word_out;
`ifdef SCRAM_SWAP_COUNT_EN
  logic [7:0]  swap_cnt;
`endif

  word_scramble_ctrl dut (
    .clk(clk), .rst(rst), .load_pls(load_pls), .word_in(word_in),
    .lett_num(lett_num), .scram_pls(scram_pls), .flip_pls(flip_pls),
    .ind1(ind1), .ind2(ind2), .busy(busy), .is_correct(is_correct),
    .flip_err(flip_err), .word_out(word_out)
`ifdef SCRAM_SWAP_COUNT_EN
    , .swap_cnt(swap_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: letters as plain integer arrays
  int         m_tgt[6];
  int         m_wrk[6];
  int         m_cnt;
  int         m_swc;
  logic [7:0] m_lfsr;

  typedef struct {
    logic [29:0] win;
    logic [2:0]  ln;
    logic [2:0]  i1;
    logic [2:0]  i2;
    logic [29:0] exp_load;
    logic [29:0] exp_word;
    logic        exp_err;
    logic        exp_corr;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [29:0] mk(input int s0, input int s1, input int s2,
                                     input int s3, input int s4, input int s5);
    return {5'(s5), 5'(s4), 5'(s3), 5'(s2), 5'(s1), 5'(s0)};
  endfunction

  function automatic logic [29:0] pk(input int w[6]);
    logic [29:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*5 +: 5] = 5'(w[i]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset;
    for (int i = 0; i < 6; i++) begin m_tgt[i] = 0; m_wrk[i] = 0; end
    m_cnt = 6; m_swc = 0; m_lfsr = 8'hA5;
  endtask

  task automatic m_load(input logic [29:0] w, input int ln);
    m_cnt = (ln < 4) ? 4 : ((ln > 6) ? 6 : ln);
    for (int i = 0; i < 6; i++) begin
      m_tgt[i] = (i < ln) ? int'(w[i*5 +: 5]) : 0;
      m_wrk[i] = m_tgt[i];
    end
    m_swc = 0;
  endtask

  function automatic bit m_match();
    for (int i = 0; i < 6; i++) if (m_wrk[i] != m_tgt[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_swap(input int x, input int y);
    int t;
    t = m_wrk[x]; m_wrk[x] = m_wrk[y]; m_wrk[y] = t;
  endtask

  task automatic m_scramble;
    int a, b;
    m_swc = 0;
    for (int n = 0; n < 8; n++) begin
      a = m_lfsr % 8;
      b = (m_lfsr / 8) % 8;
      if (a >= m_cnt) a -= m_cnt;
      if (b >= m_cnt) b -= m_cnt;
      if (a == b) b = (a + 1) % m_cnt;
      m_swap(a, b);
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
    end
    if (m_match() && m_wrk[0] != m_wrk[1]) m_swap(0, 1);
  endtask

  task automatic do_load(input logic [29:0] w, input logic [2:0] ln);
    word_in = w; lett_num = ln; load_pls = 1'b1;
    tick;
    load_pls = 1'b0;
    m_load(w, int'(ln));
    chk("load_word", 64'(word_out), 64'(pk(m_wrk)));
    chk("load_busy", 64'(busy), 64'd0);
  endtask

  task automatic do_flip(input logic [2:0] i1, input logic [2:0] i2);
    bit err, corr;
    ind1 = i1; ind2 = i2; flip_pls = 1'b1;
    tick;
    flip_pls = 1'b0;
    err = (int'(i1) >= m_cnt) || (int'(i2) >= m_cnt);
    corr = 1'b0;
    if (!err) begin
      m_swap(int'(i1), int'(i2));
      corr = m_match();
      if (m_swc < 255) m_swc++;
    end
    chk("flip_err", 64'(flip_err), 64'(err));
    chk("flip_word", 64'(word_out), 64'(pk(m_wrk)));
    chk("flip_busy", 64'(busy), 64'(!err));
`ifdef SCRAM_SWAP_COUNT_EN
    chk("swap_cnt", 64'(swap_cnt), 64'(m_swc));
`endif
    tick;
    chk("flip_corr", 64'(is_correct), 64'(corr));
    chk("flip_err_clr", 64'(flip_err), 64'd0);
    chk("flip_idle", 64'(busy), 64'd0);
  endtask

  task automatic do_scramble(input bit fd);
    int n;
    bit saw_corr, saw_err;
    scram_pls = 1'b1;
    if (fd) begin flip_pls = 1'b1; ind1 = 3'd0; ind2 = 3'd1; end
    tick;
    scram_pls = 1'b0; flip_pls = 1'b0;
    n = 0; saw_corr = 1'b0; saw_err = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (is_correct) saw_corr = 1'b1;
      if (flip_err) saw_err = 1'b1;
      flip_pls = fd && (n == 3);
      tick;
    end
    flip_pls = 1'b0;
    m_scramble();
    chk("scr_busy_cycles", 64'(n), 64'd9);
    chk("scr_no_corr", 64'(saw_corr), 64'd0);
    chk("scr_no_err", 64'(saw_err), 64'd0);
    chk("scr_word", 64'(word_out), 64'(pk(m_wrk)));
`ifdef SCRAM_SWAP_COUNT_EN
    chk("scr_swap_cnt", 64'(swap_cnt), 64'd0);
`endif
  endtask

  task automatic do_reset;
    rst = 1'b0;
    #1;
    chk("rst_busy_async", 64'(busy), 64'd0);
    chk("rst_word_async", 64'(word_out), 64'd0);
    tick;
    tick;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_word", 64'(word_out), 64'd0);
    chk("rst_corr", 64'(is_correct), 64'd0);
    chk("rst_err", 64'(flip_err), 64'd0);
`ifdef SCRAM_SWAP_COUNT_EN
    chk("rst_swap_cnt", 64'(swap_cnt), 64'd0);
`endif
    rst = 1'b1;
    m_reset();
    tick;
  endtask

  initial begin
    logic [29:0] abcd;
    logic [29:0] exp1;
    logic [29:0] w;
    int          hits;
    int          op;

    load_pls = 1'b0; scram_pls = 1'b0; flip_pls = 1'b0;
    word_in = '0; lett_num = 3'd0; ind1 = 3'd0; ind2 = 3'd0;
    rst = 1'b1;
    m_reset();
    #2;
    do_reset();
    abcd = mk(1, 2, 3, 4, 0, 0);

    // after reset the active count is MAX_LETT: slot 5 flips are legal
    do_flip(3'd5, 3'd0);

    tbl[0] = '{mk(1,2,3,4,5,6),       3'd4, 3'd0, 3'd1, mk(1,2,3,4,0,0),       mk(2,1,3,4,0,0),       1'b0, 1'b0};
    tbl[1] = '{mk(1,2,3,4,0,0),       3'd4, 3'd4, 3'd0, mk(1,2,3,4,0,0),       mk(1,2,3,4,0,0),       1'b1, 1'b0};
    tbl[2] = '{mk(1,2,3,4,5,6),       3'd6, 3'd5, 3'd0, mk(1,2,3,4,5,6),       mk(6,2,3,4,5,1),       1'b0, 1'b0};
    tbl[3] = '{mk(1,2,3,4,5,6),       3'd5, 3'd2, 3'd2, mk(1,2,3,4,5,0),       mk(1,2,3,4,5,0),       1'b0, 1'b1};
    tbl[4] = '{mk(1,2,3,4,5,6),       3'd2, 3'd3, 3'd1, mk(1,2,0,0,0,0),       mk(1,0,0,2,0,0),       1'b0, 1'b0};
    tbl[5] = '{mk(26,25,24,23,22,21), 3'd7, 3'd6, 3'd0, mk(26,25,24,23,22,21), mk(26,25,24,23,22,21), 1'b1, 1'b0};
    tbl[6] = '{mk(1,2,3,4,5,6),       3'd5, 3'd0, 3'd5, mk(1,2,3,4,5,0),       mk(1,2,3,4,5,0),       1'b1, 1'b0};
    tbl[7] = '{mk(3,1,3,1,0,0),       3'd4, 3'd0, 3'd2, mk(3,1,3,1,0,0),       mk(3,1,3,1,0,0),       1'b0, 1'b1};

    for (int v = 0; v < 8; v++) begin
      word_in = tbl[v].win; lett_num = tbl[v].ln; load_pls = 1'b1;
      tick;
      load_pls = 1'b0;
      m_load(tbl[v].win, int'(tbl[v].ln));
      chk("tbl_load", 64'(word_out), 64'(tbl[v].exp_load));
      ind1 = tbl[v].i1; ind2 = tbl[v].i2; flip_pls = 1'b1;
      tick;
      flip_pls = 1'b0;
      if (!tbl[v].exp_err) m_swap(int'(tbl[v].i1), int'(tbl[v].i2));
      chk("tbl_err", 64'(flip_err), 64'(tbl[v].exp_err));
      chk("tbl_word", 64'(word_out), 64'(tbl[v].exp_word));
      chk("tbl_busy", 64'(busy), 64'(!tbl[v].exp_err));
      tick;
      chk("tbl_corr", 64'(is_correct), 64'(tbl[v].exp_corr));
      chk("tbl_idle", 64'(busy), 64'd0);
    end

    // two identical flips restore the word: correct pulse for one cycle only
    do_load(abcd, 3'd4);
    do_flip(3'd0, 3'd1);
    do_flip(3'd0, 3'd1);
    chk("corr_pulse_hi", 64'(word_out), 64'(abcd));
    tick;
    chk("corr_pulse_lo", 64'(is_correct), 64'd0);

    // first scramble from the seed
    do_load(abcd, 3'd4);
    do_scramble(1'b0);
    exp1 = pk(m_wrk);
    hits = 0;
    for (int l = 1; l <= 4; l++) begin
      int c;
      c = 0;
      for (int i = 0; i < 4; i++) begin
        w = word_out;
        if (int'(w[i*5 +: 5]) == l) c++;
      end
      if (c == 1) hits++;
    end
    chk("scr_perm", 64'(hits), 64'd4);
    chk("scr_differs", 64'(word_out != abcd), 64'd1);
    chk("scr_tail_zero", 64'(word_out[29:20]), 64'd0);

    // scramble and flip together, plus a flip mid-scramble: flips dropped
    do_load(mk(5, 9, 5, 2, 7, 0), 3'd5);
    do_scramble(1'b1);

    // load during scramble cycle 3 aborts
    do_load(abcd, 3'd4);
    scram_pls = 1'b1;
    tick;
    scram_pls = 1'b0;
    tick;
    tick;
    word_in = mk(8, 9, 10, 11, 12, 13); lett_num = 3'd6; load_pls = 1'b1;
    tick;
    load_pls = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_word", 64'(word_out), 64'(mk(8, 9, 10, 11, 12, 13)));
    do_reset();

    // reset mid-scramble then reproduce the seed sequence
    do_load(abcd, 3'd4);
    scram_pls = 1'b1;
    tick;
    scram_pls = 1'b0;
    tick;
    tick;
    do_reset();
    do_load(abcd, 3'd4);
    do_scramble(1'b0);
    chk("reseed_repeat", 64'(word_out), 64'(exp1));

    // randomized mix against the model
    for (int r = 0; r < 60; r++) begin
      op = int'($urandom_range(0, 9));
      if (op < 2) begin
        w = '0;
        for (int i = 0; i < 6; i++) w[i*5 +: 5] = 5'($urandom_range(1, 4));
        do_load(w, 3'($urandom_range(3, 7)));
      end else if (op < 4) begin
        do_scramble(1'b0);
      end else begin
        do_flip(3'($urandom_range(0, 6)), 3'($urandom_range(0, 6)));
      end
    end

`ifdef SCRAM_SWAP_COUNT_EN
    do_load(abcd, 3'd4);
    for (int f = 0; f < 300; f++) do_flip(3'd0, 3'd1);
    chk("swap_cnt_sat", 64'(swap_cnt), 64'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
